// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int MAX_CLIENTS = 16;
  localparam int LOCK_CNT_W  = 16;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from last+1, wrapping at N.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_mask,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    // NOTE: every output gets a default before the search loop so no latch is inferred.
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = int'(last) + off;
      if (idx >= N) idx = idx - N;
      if (!any && req_mask[IW'(idx)]) begin
        any                 = 1'b1;
        gnt_onehot[IW'(idx)] = 1'b1;
        gnt_idx             = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_CLIENTS byte producers: round-robin accept,
// one req pulse per byte, optional message lock with stall timeout.
module uart_tx_arbiter #(
  parameter int NUM_CLIENTS  = 4,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int IDW = $clog2(NUM_CLIENTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CLIENTS-1:0]   cli_valid,
  input  logic [8*NUM_CLIENTS-1:0] cli_data,
  input  logic [NUM_CLIENTS-1:0]   cli_last,
  output logic [NUM_CLIENTS-1:0]   cli_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_req,
  input  logic                     tx_empty,
  output logic [IDW-1:0]           grant_id,
  output logic                     lock_active,
  output logic                     busy,
  output logic                     proto_err
);
  import uart_pkg::*;

  arb_state_t            state_q;
  logic [7:0]            tx_data_q;
  logic                  tx_req_q;
  logic [IDW-1:0]        grant_q;
  logic                  lock_q;
  logic                  proto_err_q;
  logic [LOCK_CNT_W-1:0] cnt_q;

  logic [NUM_CLIENTS-1:0] owner_mask;
  logic [NUM_CLIENTS-1:0] elig_mask;
  logic [NUM_CLIENTS-1:0] gnt_onehot;
  logic [IDW-1:0]         gnt_idx;
  logic                   gnt_any;
  logic                   accept;
  logic                   owner_stall;
  logic [LOCK_CNT_W-1:0]  cnt_inc;

  always_comb begin
    owner_mask          = '0;
    owner_mask[grant_q] = 1'b1;
  end

  assign elig_mask = lock_q ? (cli_valid & owner_mask) : cli_valid;

  rr_pick #(.N(NUM_CLIENTS)) u_rr_pick (
    .req_mask   (elig_mask),
    .last       (grant_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // Gating with rst keeps the combinational handshake quiet while reset is held.
  assign accept      = !rst && (state_q == ARB) && tx_empty && gnt_any;
  assign cli_ready   = accept ? gnt_onehot : '0;
  assign owner_stall = lock_q && !cli_valid[grant_q];
  assign cnt_inc     = cnt_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      tx_data_q   <= '0;
      tx_req_q    <= 1'b0;
      grant_q     <= IDW'(NUM_CLIENTS - 1);
      lock_q      <= 1'b0;
      proto_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      tx_req_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (accept) begin
            tx_data_q <= cli_data[8*gnt_idx +: 8];
            grant_q   <= gnt_idx;
            lock_q    <= ~cli_last[gnt_idx];
            cnt_q     <= '0;
            tx_req_q  <= 1'b1;
            state_q   <= ISSUE;
          end else if (!lock_q) begin
            cnt_q <= '0;
          end else if (owner_stall) begin
            // A stalled owner forfeits its lock once the budget is spent.
            if (cnt_inc == LOCK_CNT_W'(LOCK_TIMEOUT)) begin
              lock_q <= 1'b0;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        ISSUE: begin
          if (!tx_empty) proto_err_q <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (tx_empty) state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_req      = tx_req_q;
  assign grant_id    = grant_q;
  assign lock_active = lock_q;
  assign busy        = (state_q != ARB);
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a cycle-level uart_tx stand-in that
// captures each requested byte and stays busy for one frame.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int CPB   = 3;
  localparam int FRAME = (CPB + 1) * 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   cli_valid;
  logic [8*N-1:0] cli_data;
  logic [N-1:0]   cli_last;
  logic [N-1:0]   cli_ready;
  logic [7:0]     tx_data;
  logic           tx_req;
  logic           tx_empty;
  logic [1:0]     grant_id;
  logic           lock_active;
  logic           busy;
  logic           proto_err;

  logic       uart_empty;
  logic       force_busy;
  int         uart_cnt;
  logic [7:0] sent[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign tx_empty = uart_empty & ~force_busy;

  uart_tx_arbiter #(.NUM_CLIENTS(N), .LOCK_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cli_valid   (cli_valid),
    .cli_data    (cli_data),
    .cli_last    (cli_last),
    .cli_ready   (cli_ready),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_empty    (tx_empty),
    .grant_id    (grant_id),
    .lock_active (lock_active),
    .busy        (busy),
    .proto_err   (proto_err)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_empty <= 1'b1;
      uart_cnt   <= 0;
    end else if (tx_req && uart_empty) begin
      sent.push_back(tx_data);
      uart_empty <= 1'b0;
      uart_cnt   <= FRAME - 1;
    end else if (!uart_empty) begin
      if (uart_cnt == 0) uart_empty <= 1'b1;
      else uart_cnt <= uart_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] sent_at(input int i);
    return (sent.size() > i) ? {24'h0, sent[i]} : 32'hdead_beef;
  endfunction

  task automatic set_client(input int i, input logic [7:0] d, input logic last);
    cli_data[8*i +: 8] = d;
    cli_last[i]        = last;
    cli_valid[i]       = 1'b1;
  endtask

  task automatic do_reset();
    step();
    rst        = 1'b1;
    cli_valid  = '0;
    cli_last   = '0;
    force_busy = 1'b0;
    step();
    rst = 1'b0;
    sent.delete();
    #1;
  endtask

  task automatic wait_ready(input int idx, input string tag);
    int n = 0;
    #1;
    while (!cli_ready[idx] && n < 300) begin
      step();
      n++;
    end
    check(tag, {31'h0, cli_ready[idx]}, 32'h1);
  endtask

  task automatic wait_sent(input int cnt, input string tag);
    int n = 0;
    while (sent.size() < cnt && n < 2000) begin
      step();
      n++;
    end
    check(tag, sent.size(), cnt);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || !tx_empty) && n < 300) begin
      step();
      n++;
    end
    check(tag, {30'h0, busy, tx_empty}, 32'h1);
  endtask

  initial begin
    int  n;
    logic saw_ready;
    cli_valid  = '0;
    cli_data   = '0;
    cli_last   = '0;
    force_busy = 1'b0;
    rst        = 1'b1;
    repeat (2) step();

    // Reset values
    check("rst_tx_req", tx_req, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_cli_ready", cli_ready, 0);
    check("rst_grant_id", grant_id, 3);
    check("rst_lock", lock_active, 0);
    check("rst_busy", busy, 0);
    check("rst_proto_err", proto_err, 0);

    // Single byte from client 0
    set_client(0, 8'hA5, 1'b1);
    #1;
    check("t1_ready_in_rst", cli_ready, 0);
    rst = 1'b0;
    #1;
    check("t1_ready", cli_ready, 4'b0001);
    step();
    check("t1_tx_req", tx_req, 1);
    check("t1_tx_data", tx_data, 8'hA5);
    check("t1_grant", grant_id, 0);
    check("t1_lock", lock_active, 0);
    check("t1_busy", busy, 1);
    check("t1_ready_issue", cli_ready, 0);
    cli_valid = '0;
    step();
    check("t1_req_pulse", tx_req, 0);
    wait_sent(1, "t1_sent_cnt");
    check("t1_byte", sent_at(0), 8'hA5);
    wait_idle("t1_idle");

    // Round-robin fairness across all four clients
    do_reset();
    for (int i = 0; i < N; i++) set_client(i, 8'h10 + 8'(i), 1'b1);
    wait_sent(8, "t2_sent_cnt");
    cli_valid = '0;
    for (int i = 0; i < 8; i++) check($sformatf("t2_order%0d", i), sent_at(i), 8'h10 + (i % 4));
    check("t2_grant", grant_id, 3);
    wait_idle("t2_idle");

    // Locked three-byte message from client 2 while client 1 waits
    do_reset();
    set_client(2, 8'h01, 1'b0);
    wait_ready(2, "t3_acc1");
    step();
    check("t3_lock_set", lock_active, 1);
    check("t3_grant", grant_id, 2);
    set_client(1, 8'h55, 1'b1);
    set_client(2, 8'h02, 1'b0);
    wait_ready(2, "t3_acc2");
    step();
    set_client(2, 8'h03, 1'b1);
    wait_ready(2, "t3_acc3");
    step();
    check("t3_unlock", lock_active, 0);
    cli_valid[2] = 1'b0;
    wait_sent(4, "t3_sent_cnt");
    cli_valid = '0;
    check("t3_b0", sent_at(0), 8'h01);
    check("t3_b1", sent_at(1), 8'h02);
    check("t3_b2", sent_at(2), 8'h03);
    check("t3_b3", sent_at(3), 8'h55);
    check("t3_proto_err", proto_err, 0);
    wait_idle("t3_idle");

    // Lock timeout: client 3 stalls mid-message, client 0 waits
    do_reset();
    set_client(3, 8'h77, 1'b0);
    wait_ready(3, "t4_acc");
    step();
    check("t4_lock_set", lock_active, 1);
    cli_valid = '0;
    set_client(0, 8'h99, 1'b1);
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    n = 0;
    saw_ready = 1'b0;
    while (lock_active && n < 100) begin
      if (cli_ready != '0) saw_ready = 1'b1;
      n++;
      step();
    end
    check("t4_stall_cycles", n, 8);
    check("t4_no_ready_locked", saw_ready, 0);
    check("t4_ready_after", cli_ready, 4'b0001);
    wait_sent(2, "t4_sent_cnt");
    cli_valid = '0;
    check("t4_byte", sent_at(1), 8'h99);
    wait_idle("t4_idle");

    // Reset asserted five cycles into a frame
    do_reset();
    set_client(0, 8'h42, 1'b1);
    wait_ready(0, "t5_acc");
    step();
    cli_valid = '0;
    repeat (5) step();
    check("t5_busy_before", busy, 1);
    rst = 1'b1;
    set_client(0, 8'h42, 1'b1);
    set_client(1, 8'h11, 1'b1);
    #1;
    check("t5_rst_req", tx_req, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ready", cli_ready, 0);
    check("t5_rst_grant", grant_id, 3);
    step();
    rst = 1'b0;
    #1;
    check("t5_post_ready", cli_ready, 4'b0001);
    step();
    check("t5_post_grant", grant_id, 0);
    check("t5_post_data", tx_data, 8'h42);
    cli_valid = '0;
    wait_idle("t5_idle");

    // Transmitter not empty during ISSUE sets a sticky error
    do_reset();
    check("t6_err_clear", proto_err, 0);
    set_client(0, 8'h5A, 1'b1);
    wait_ready(0, "t6_acc");
    step();
    force_busy = 1'b1;
    cli_valid  = '0;
    #1;
    check("t6_issue_req", tx_req, 1);
    step();
    force_busy = 1'b0;
    #1;
    check("t6_err_set", proto_err, 1);
    wait_idle("t6_idle1");
    set_client(1, 8'h6B, 1'b1);
    wait_ready(1, "t6_acc2");
    step();
    cli_valid = '0;
    wait_idle("t6_idle2");
    check("t6_err_sticky", proto_err, 1);
    check("t6_byte", sent_at(sent.size() - 1), 8'h6B);
    step();
    rst = 1'b1;
    #1;
    check("t6_err_rst", proto_err, 0);
    step();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
